// File: rtl/i2s_master_txrx_if.sv
// Bus bundle for i2s_master_txrx: DAC sample handshake, ADC sample strobe and I2S pins.
// The master modport is the serial engine's view; slave is the audio-side/codec view.
interface i2s_master_txrx_if #(
   parameter int DATA_W = 16
);
   logic              tx_valid;
   logic              tx_ready;
   logic [DATA_W-1:0] tx_left;
   logic [DATA_W-1:0] tx_right;
   logic              tx_underrun;
   logic              rx_valid;
   logic [DATA_W-1:0] rx_left;
   logic [DATA_W-1:0] rx_right;
   logic              i2s_bclk;
   logic              i2s_lrclk;
   logic              i2s_dacdat;
   logic              i2s_adcdat;

   modport master (
      input  tx_valid, tx_left, tx_right, i2s_adcdat,
      output tx_ready, tx_underrun, rx_valid, rx_left, rx_right,
             i2s_bclk, i2s_lrclk, i2s_dacdat
   );

   modport slave (
      output tx_valid, tx_left, tx_right, i2s_adcdat,
      input  tx_ready, tx_underrun, rx_valid, rx_left, rx_right,
             i2s_bclk, i2s_lrclk, i2s_dacdat
   );
endinterface

// File: rtl/i2s_master_txrx.sv
// Full-duplex I2S master: BCLK/LRCLK generation, one-deep DAC holding register, ADC deserialiser.
// Define I2S_LOOPBACK_EN to feed the RX sampler from the internal DAC data register.
//
// Holding register FSM:
//   state      | meaning
//   HOLD_EMPTY | no pending DAC pair, tx_ready=1, accepts on tx_valid
//   HOLD_FULL  | pair waiting for the next frame start, tx_ready=0
module i2s_master_txrx #(
   parameter int DATA_W   = 16,
   parameter int SLOT_W   = 32,
   parameter int BCLK_DIV = 4,
   parameter int MODE     = 0
) (
   input logic               clk,
   input logic               rst_n,
   i2s_master_txrx_if.master bus
);
   localparam int FRAME_W = 2 * SLOT_W;
   localparam int DIV_W   = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
   localparam int BIT_W   = $clog2(FRAME_W);
   localparam int OFF     = (MODE == 0) ? 1 : 0;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);
   localparam logic [BIT_W-1:0] SLOT_LEN = BIT_W'(SLOT_W);

   typedef enum logic {HOLD_EMPTY, HOLD_FULL} hold_state_t;

   logic [DIV_W-1:0]   div_cnt;
   logic               bclk_q;
   logic               div_tc;
   logic               rise_ev;
   logic               fall_ev;
   logic [BIT_W-1:0]   bit_cnt;
   logic [BIT_W-1:0]   bit_nxt;
   logic               lrclk_q;
   logic               frame_start;
   hold_state_t        hold_state;
   hold_state_t        hold_state_nxt;
   logic               tx_accept;
   logic               hold_to_shift;
   logic               underrun_set;
   logic [DATA_W-1:0]  hold_l;
   logic [DATA_W-1:0]  hold_r;
   logic [FRAME_W-1:0] shift_q;
   logic [FRAME_W-1:0] shift_src;
   logic               dac_q;
   logic               underrun_q;
   logic               rx_bit;
   logic               rx_right_slot;
   logic [BIT_W-1:0]   slot_idx;
   logic [BIT_W-1:0]   win_idx;
   logic               in_window;
   logic               rx_last;
   logic [DATA_W-1:0]  rx_sh_l;
   logic [DATA_W-1:0]  rx_sh_r;
   logic [DATA_W:0]    rx_l_ext;
   logic [DATA_W:0]    rx_r_ext;
   logic               rx_valid_q;
   logic [DATA_W-1:0]  rx_left_q;
   logic [DATA_W-1:0]  rx_right_q;

   // Left-aligns a sample inside its slot, leaving the I2S one-bit delay in MODE 0.
   function automatic logic [SLOT_W-1:0] slot_image(input logic [DATA_W-1:0] s);
      return SLOT_W'(s) << (SLOT_W - DATA_W - OFF);
   endfunction

   assign div_tc  = (div_cnt == DIV_LAST);
   assign rise_ev = div_tc & ~bclk_q;
   assign fall_ev = div_tc & bclk_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= '0;
         bclk_q  <= 1'b0;
      end else if (div_tc) begin
         div_cnt <= '0;
         bclk_q  <= ~bclk_q;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   assign bit_nxt     = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
   assign frame_start = fall_ev & (bit_cnt == BIT_LAST);

   // Reset parks the counter on the last right-slot bit so the first fall starts a frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt <= BIT_LAST;
         lrclk_q <= 1'b1;
      end else if (fall_ev) begin
         bit_cnt <= bit_nxt;
         lrclk_q <= (bit_nxt >= SLOT_LEN);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) hold_state <= HOLD_EMPTY;
      else        hold_state <= hold_state_nxt;
   end

   always_comb begin
      hold_state_nxt = hold_state;
      tx_accept      = 1'b0;
      hold_to_shift  = 1'b0;
      underrun_set   = 1'b0;
      case (hold_state)
         HOLD_EMPTY: begin
            underrun_set = frame_start;
            if (bus.tx_valid) begin
               tx_accept      = 1'b1;
               hold_state_nxt = HOLD_FULL;
            end
         end
         HOLD_FULL: begin
            if (frame_start) begin
               hold_to_shift  = 1'b1;
               hold_state_nxt = HOLD_EMPTY;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_l <= '0;
         hold_r <= '0;
      end else if (tx_accept) begin
         hold_l <= bus.tx_left;
         hold_r <= bus.tx_right;
      end
   end

   // On frame start the freshly loaded image's MSB goes straight out as bit 0.
   assign shift_src = !frame_start  ? shift_q :
                      hold_to_shift ? {slot_image(hold_l), slot_image(hold_r)} : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_q <= '0;
         dac_q   <= 1'b0;
      end else if (fall_ev) begin
         dac_q   <= shift_src[FRAME_W-1];
         shift_q <= {shift_src[FRAME_W-2:0], 1'b0};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) underrun_q <= 1'b0;
      else        underrun_q <= underrun_set;
   end

`ifdef I2S_LOOPBACK_EN
   assign rx_bit = dac_q;
`else
   assign rx_bit = bus.i2s_adcdat;
`endif

   // bit_cnt only moves on falls, so at a rise it names the bit currently on the wire.
   assign rx_right_slot = (bit_cnt >= SLOT_LEN);
   assign slot_idx      = rx_right_slot ? bit_cnt - SLOT_LEN : bit_cnt;
   assign win_idx       = slot_idx - BIT_W'(OFF);
   assign in_window     = (win_idx < BIT_W'(DATA_W));
   assign rx_last       = rx_right_slot & (win_idx == BIT_W'(DATA_W - 1));
   assign rx_l_ext      = {rx_sh_l, rx_bit};
   assign rx_r_ext      = {rx_sh_r, rx_bit};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_sh_l    <= '0;
         rx_sh_r    <= '0;
         rx_left_q  <= '0;
         rx_right_q <= '0;
         rx_valid_q <= 1'b0;
      end else begin
         rx_valid_q <= 1'b0;
         if (rise_ev && in_window) begin
            if (rx_right_slot) rx_sh_r <= rx_r_ext[DATA_W-1:0];
            else               rx_sh_l <= rx_l_ext[DATA_W-1:0];
            if (rx_last) begin
               rx_left_q  <= rx_sh_l;
               rx_right_q <= rx_r_ext[DATA_W-1:0];
               rx_valid_q <= 1'b1;
            end
         end
      end
   end

   assign bus.tx_ready    = (hold_state == HOLD_EMPTY);
   assign bus.tx_underrun = underrun_q;
   assign bus.rx_valid    = rx_valid_q;
   assign bus.rx_left     = rx_left_q;
   assign bus.rx_right    = rx_right_q;
   assign bus.i2s_bclk    = bclk_q;
   assign bus.i2s_lrclk   = lrclk_q;
   assign bus.i2s_dacdat  = dac_q;
endmodule

// File: tb/tb_i2s_master_txrx.sv
// Bench for i2s_master_txrx: an I2S (MODE 0) and a left-justified (MODE 1) instance run in lockstep
// against a frame-level model; honours I2S_LOOPBACK_EN for the expected RX data.
module tb_i2s_master_txrx;
   localparam int DW  = 16;
   localparam int SW  = 32;
   localparam int DIV = 4;
   localparam int FB  = 2 * SW;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   i2s_master_txrx_if #(.DATA_W(DW)) if0 ();
   i2s_master_txrx_if #(.DATA_W(DW)) if1 ();

   i2s_master_txrx #(.DATA_W(DW), .SLOT_W(SW), .BCLK_DIV(DIV), .MODE(0)) u_i2s (
      .clk(clk), .rst_n(rst_n), .bus(if0));
   i2s_master_txrx #(.DATA_W(DW), .SLOT_W(SW), .BCLK_DIV(DIV), .MODE(1)) u_lj (
      .clk(clk), .rst_n(rst_n), .bus(if1));

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   logic [DW-1:0] stim_l[$];
   logic [DW-1:0] stim_r[$];
   int acc_cyc[$];
   logic hold_v = 1'b0;
   logic [DW-1:0] hold_l, hold_r, cur_l, cur_r;
   logic cur_under;
   logic frame_act = 1'b0;
   logic first_frame = 1'b1;
   int fstart, bitk = 0, nframes = 0;
   int last_rise = -1, last_lr = -1;
   logic [FB-1:0] cap0, cap1, adc0, adc1;
   int under_n0, under_n1, under_at0, under_at1, rxv_n0, rxv_n1;
   logic [DW-1:0] rxl0, rxr0, rxl1, rxr1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Serial frame image, bit k of the frame at position FB-1-k.
   function automatic logic [FB-1:0] frame_of(input int mode, input logic [DW-1:0] l,
                                              input logic [DW-1:0] r);
      logic [FB-1:0] f;
      int off, j;
      f = '0;
      off = (mode == 0) ? 1 : 0;
      for (int k = 0; k < FB; k++) begin
         j = k % SW;
         if (j >= off && j < off + DW)
            f[FB-1-k] = (k < SW) ? l[DW-1-(j-off)] : r[DW-1-(j-off)];
      end
      return f;
   endfunction

   function automatic logic [2*DW-1:0] rx_of(input int mode, input logic [FB-1:0] a);
      logic [DW-1:0] l, r;
      int off;
      off = (mode == 0) ? 1 : 0;
      for (int i = 0; i < DW; i++) begin
         l[DW-1-i] = a[FB-1-(off+i)];
         r[DW-1-i] = a[FB-1-(SW+off+i)];
      end
      return {l, r};
   endfunction

   task automatic drive_tx();
      if0.tx_valid = (stim_l.size() > 0);
      if0.tx_left  = (stim_l.size() > 0) ? stim_l[0] : '0;
      if0.tx_right = (stim_r.size() > 0) ? stim_r[0] : '0;
      if1.tx_valid = if0.tx_valid;
      if1.tx_left  = if0.tx_left;
      if1.tx_right = if0.tx_right;
   endtask

   task automatic push_pair(input logic [DW-1:0] l, input logic [DW-1:0] r);
      stim_l.push_back(l);
      stim_r.push_back(r);
      drive_tx();
   endtask

   task automatic finalize();
      logic [FB-1:0] e0, e1;
      logic [2*DW-1:0] r0, r1;
      e0 = cur_under ? '0 : frame_of(0, cur_l, cur_r);
      e1 = cur_under ? '0 : frame_of(1, cur_l, cur_r);
      chk("dac_frame_i2s", cap0, e0);
      chk("dac_frame_lj", cap1, e1);
      chk("underrun_pulses_i2s", under_n0, cur_under);
      chk("underrun_pulses_lj", under_n1, cur_under);
      if (cur_under) begin
         chk("underrun_cycle_i2s", under_at0, fstart);
         chk("underrun_cycle_lj", under_at1, fstart);
      end
      chk("rx_valid_pulses_i2s", rxv_n0, 1);
      chk("rx_valid_pulses_lj", rxv_n1, 1);
`ifdef I2S_LOOPBACK_EN
      r0 = cur_under ? '0 : {cur_l, cur_r};
      r1 = r0;
`else
      r0 = rx_of(0, adc0);
      r1 = rx_of(1, adc1);
`endif
      chk("rx_pair_i2s", {rxl0, rxr0}, r0);
      chk("rx_pair_lj", {rxl1, rxr1}, r1);
      nframes++;
      if (nframes == 1) begin
         chk("frame1_i2s_image", cap0, 64'h52E18000_00008000);
         chk("frame1_lj_image", cap1, 64'hA5C30000_00010000);
      end
   endtask

   // One clk cycle; observes #1 after the rising edge and updates the frame-level model.
   task automatic step();
      logic acc, pb, plr, b0, b1;
      acc = if0.tx_valid && if0.tx_ready;
      pb  = if0.i2s_bclk;
      plr = if0.i2s_lrclk;
      @(posedge clk);
      #1;
      cyc++;
      if (!pb && if0.i2s_bclk) begin
         if (last_rise >= 0) chk("bclk_period", cyc - last_rise, 2 * DIV);
         last_rise = cyc;
         if (frame_act) begin
            chk("lrclk_slot", if0.i2s_lrclk, (bitk >= SW) ? 64'd1 : 64'd0);
            cap0[FB-1-bitk] = if0.i2s_dacdat;
            cap1[FB-1-bitk] = if1.i2s_dacdat;
         end
      end
      if (plr != if0.i2s_lrclk) begin
         chk("lrclk_edge_on_bclk_fall", {pb, if0.i2s_bclk}, 64'd2);
         if (last_lr >= 0) chk("lrclk_half_period", cyc - last_lr, SW * 2 * DIV);
         last_lr = cyc;
      end
      if (pb && !if0.i2s_bclk) begin
         if (plr && !if0.i2s_lrclk) begin
            if (frame_act) finalize();
            if (first_frame) begin
               chk("first_frame_start", cyc, 2 * DIV);
               first_frame = 1'b0;
            end
            frame_act = 1'b1;
            bitk      = 0;
            fstart    = cyc;
            cur_under = !hold_v;
            cur_l     = hold_v ? hold_l : '0;
            cur_r     = hold_v ? hold_r : '0;
            hold_v    = 1'b0;
            under_n0 = 0; under_n1 = 0; rxv_n0 = 0; rxv_n1 = 0;
         end else if (frame_act) begin
            bitk++;
         end
         if (frame_act) begin
            b0 = 1'($urandom_range(0, 1));
            b1 = 1'($urandom_range(0, 1));
            if0.i2s_adcdat = b0;
            if1.i2s_adcdat = b1;
            adc0[FB-1-bitk] = b0;
            adc1[FB-1-bitk] = b1;
         end
      end
      if (acc) begin
         hold_v = 1'b1;
         hold_l = stim_l.pop_front();
         hold_r = stim_r.pop_front();
         acc_cyc.push_back(cyc);
         drive_tx();
      end
      chk("tx_ready_i2s", if0.tx_ready, !hold_v);
      chk("tx_ready_lj", if1.tx_ready, !hold_v);
      if (if0.tx_underrun) begin under_n0++; under_at0 = cyc; end
      if (if1.tx_underrun) begin under_n1++; under_at1 = cyc; end
      if (if0.rx_valid) begin rxv_n0++; rxl0 = if0.rx_left; rxr0 = if0.rx_right; end
      if (if1.rx_valid) begin rxv_n1++; rxl1 = if1.rx_left; rxr1 = if1.rx_right; end
   endtask

   task automatic run_frames(input int n, input int budget);
      int tgt, g;
      tgt = nframes + n;
      g = 0;
      while (nframes < tgt && g < budget) begin
         step();
         g++;
      end
      if (nframes < tgt) chk("frame_timeout", nframes, tgt);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_i2s"}, {if0.i2s_bclk, if0.i2s_lrclk, if0.i2s_dacdat, if0.tx_ready,
                          if0.tx_underrun, if0.rx_valid, if0.rx_left, if0.rx_right},
          {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0});
      chk({tag, "_lj"}, {if1.i2s_bclk, if1.i2s_lrclk, if1.i2s_dacdat, if1.tx_ready,
                         if1.tx_underrun, if1.rx_valid, if1.rx_left, if1.rx_right},
          {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0});
   endtask

   initial begin
      int g, d;
      if0.i2s_adcdat = 1'b0;
      if1.i2s_adcdat = 1'b0;
      drive_tx();
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset_values");

      // Two pairs offered back to back before the first frame.
      push_pair(16'hA5C3, 16'h0001);
      push_pair(16'h1234, 16'hFEDC);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc = 0;
      run_frames(3, 2000);
      chk("first_accept_cycle", (acc_cyc.size() > 0) ? acc_cyc[0] : -1, 1);
      chk("second_accept_cycle", (acc_cyc.size() > 1) ? acc_cyc[1] : -1, 2 * DIV + 1);

      for (int f = 0; f < 6; f++) begin
         d = $urandom_range(0, 700);
         for (int i = 0; i < d; i++) step();
         if ($urandom_range(0, 3) != 0)
            push_pair(16'($urandom), 16'($urandom));
         if ($urandom_range(0, 2) == 0)
            push_pair(16'($urandom), 16'($urandom));
         run_frames(1, 1500);
      end

      // Mid-frame reset with a pair sitting in the holding register.
      stim_l.delete();
      stim_r.delete();
      push_pair(16'h5A5A, 16'h3C3C);
      g = 0;
      while (!(hold_v && frame_act && bitk >= 20) && g < 2000) begin
         step();
         g++;
      end
      if (g >= 2000) chk("midframe_setup_timeout", g, 0);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("async_reset_values");
      stim_l.delete();
      stim_r.delete();
      drive_tx();
      hold_v = 1'b0;
      frame_act = 1'b0;
      first_frame = 1'b1;
      last_rise = -1;
      last_lr = -1;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc = 0;
      for (int i = 0; i < 100; i++) step();
      push_pair(16'h8001, 16'h7FFE);
      run_frames(2, 1500);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/i2s_master_txrx.md
Name: i2s_master_txrx

Overview:
Parametrised full-duplex I2S master serving as the serial engine under the audio top level. It generates BCLK and LRCLK from the system clock, and serialises stereo DAC samples delivered through a one-deep valid/ready holding register. It also deserialises stereo ADC samples into a one-cycle valid strobe. Sample width, slot width, BCLK divider and framing mode (Philips I2S or left-justified) are generalised.

Parameters:
DATA_W, 16, sample bits per channel; must be <= SLOT_W-1 when MODE=0 and <= SLOT_W when MODE=1
SLOT_W, 32, BCLK periods per channel slot (frame = 2*SLOT_W)
BCLK_DIV, 4, clk cycles per BCLK half-period (>=1); BCLK period = 2*BCLK_DIV clk
MODE, 0, 0 = I2S (MSB one BCLK after LRCLK edge), 1 = left-justified (MSB on LRCLK edge)

Ports:
clk  in  1  system clock, single domain
rst_n  in  1  asynchronous active-low reset
tx_valid  in  1  DAC sample pair offered
tx_ready  out  1  holding register empty; transfer on tx_valid&&tx_ready
tx_left  in  DATA_W  left DAC sample, two's complement
tx_right  in  DATA_W  right DAC sample
tx_underrun  out  1  one-clk pulse: frame started with holding register empty
rx_valid  out  1  one-clk pulse: rx_left/rx_right updated
rx_left  out  DATA_W  last received left sample
rx_right  out  DATA_W  last received right sample
i2s_bclk  out  1  bit clock
i2s_lrclk  out  1  word select, shared by DAC and ADC; 0 = left slot
i2s_dacdat  out  1  serial DAC data
i2s_adcdat  in  1  serial ADC data, externally synchronised

Behaviour:
- Reset (async, immediate): i2s_bclk=0, i2s_lrclk=1, i2s_dacdat=0, tx_ready=1, tx_underrun=0, rx_valid=0, rx_left=rx_right=0, div_cnt=0, bit_cnt=2*SLOT_W-1, holding and shift registers cleared. Reset mid-frame discards any pending sample.
- Divider: div_cnt counts 0..BCLK_DIV-1; at BCLK_DIV-1 it wraps and i2s_bclk toggles.
  - Rise event: the cycle where i2s_bclk=0 and div_cnt=BCLK_DIV-1.
  - Fall event: the cycle where i2s_bclk=1 and div_cnt=BCLK_DIV-1.
- Bit counter: bit_cnt advances mod 2*SLOT_W on each fall event. i2s_lrclk is registered as (next bit_cnt >= SLOT_W), so it changes with BCLK falling edges.
- Frame start: the fall event where bit_cnt wraps to 0. The first frame starts 2*BCLK_DIV clk after reset release.
- TX handshake:
  - Holding register accepts on tx_valid&&tx_ready; tx_ready deasserts the cycle after acceptance.
  - At frame start, a full holding register moves to the 2*SLOT_W shift register and tx_ready returns to 1 on the next cycle.
  - Acceptance coinciding with frame start is not loaded that frame; it is loaded at the next frame start.
  - Empty at frame start: shift register loads all zeros and tx_underrun pulses for 1 clk.
- Slot image: MODE=0 gives {1'b0, sample, zeros}; MODE=1 gives {sample, zeros}. Left slot first, MSB first. i2s_dacdat is updated from the shift MSB on every fall event, so the output is stable across each BCLK rising edge.
- RX:
  - i2s_adcdat is sampled on every rise event. Slot-relative bit index k is captured when off <= k < off+DATA_W, where off = 1 for MODE=0 and 0 for MODE=1.
  - On the rise event of the last right-channel data bit, the right sample completes. rx_left/rx_right update together and rx_valid pulses 1 clk on the following cycle.
  - Bits outside the window are ignored.
- Defaults give a 512-clk frame (48 kHz at 24.576 MHz clk).

Optional Feature:
I2S_LOOPBACK_EN: when defined, the RX sampler reads the internal i2s_dacdat register instead of i2s_adcdat, and i2s_adcdat is ignored. rx_valid then returns the transmitted pair in the same frame. When undefined, i2s_adcdat is used and no loopback logic exists.

Test Plan:
- Clocking, defaults: release reset and measure. Required: i2s_bclk period 8 clk; i2s_lrclk period 512 clk with 256-clk halves; every i2s_lrclk edge coincident with an i2s_bclk falling edge.
- I2S TX (MODE=0): accept left=16'hA5C3, right=16'h0001 before the first frame. Required: left slot bit0=0, bits1..16 = A5C3 MSB first, bits17..31=0; right slot bit16=1, all other right-slot bits 0.
- Left-justified (MODE=1): same data. Required: A5C3 MSB at left slot bit0, right sample LSB at right slot bit15; rx window shifted identically.
- Underrun: no tx_valid for one frame. Required: i2s_dacdat=0 for all 64 bits; tx_underrun exactly 1 clk at frame start; tx_ready stays 1.
- Backpressure: drive tx_valid continuously with two pairs. Required: first pair accepted, tx_ready low until the cycle after the next frame start, then second pair accepted; no pair lost or duplicated.
- RX with I2S_LOOPBACK_EN defined: tx 16'h1234/16'hFEDC. Required: rx_valid pulses once, in the same frame, with rx_left=16'h1234 and rx_right=16'hFEDC. Also assert rst_n low mid-frame and confirm all outputs take reset values immediately.
